sar_result_reader: RTL and testbench
====================================

Name: sar_result_reader

Overview:
- Host-side reader for the 10-bit SAR conversion controller.
- Issues single-cycle cnvst pulses, either periodically or on demand, and waits for eoc.
- Captures the SAR code into a small FIFO and presents it on a valid/ready stream.
- Flags missing eoc (timeout) and dropped results (overflow); sits between the SAR logic and the digital back end/readout.

Parameters:
- DATA_W, 10, SAR code width.
- FIFO_DEPTH, 4, result buffer entries (power of two, >=2).
- TIMEOUT, 31, max cycles from cnvst to eoc before abort.
- RATE_W, 8, width of conversion-period input.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  periodic conversion mode enable.
- rate  in  RATE_W  period in cycles between periodic triggers; 0 = back-to-back.
- single  in  1  one-shot conversion request, pulse.
- cnvst  out  1  conversion start to SAR logic, one-cycle pulse.
- sar_in  in  DATA_W  SAR result code.
- eoc_in  in  1  end of conversion; sar_in is valid in the same cycle.
- m_data  out  DATA_W  FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accept.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky: result dropped because FIFO was full.
- timeout  out  1  sticky: conversion aborted with no eoc.
- clr_flags  in  1  clears overflow and timeout.
- conv_count  out  16  accepted-result counter, wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0) forces all of the following, immediately and also mid-conversion:
  - state=IDLE; cnvst=0, busy=0, m_valid=0, m_data=0.
  - overflow=0, timeout=0, conv_count=0.
  - FIFO empty; pending=0; period and timeout counters=0.
- Trigger sources:
  - single=1 sets pending.
  - When enable=1, the period counter loads rate when it is 0 and otherwise decrements. At a 0-reach with enable=1 it sets pending.
  - With enable=0 the period counter holds 0.
  - pending is one deep; extra triggers while pending=1 are discarded.
- FSM states IDLE, START, WAIT:
  - IDLE: if pending=1, go to START and clear pending.
  - START: cnvst=1 for exactly this cycle (registered output), clear the timeout counter, go to WAIT.
  - WAIT, eoc_in=1: push sar_in, go to IDLE.
  - WAIT, eoc_in=0: increment the timeout counter. When the counter reaches TIMEOUT, set timeout, push nothing, go to IDLE.
  - Minimum spacing between cnvst pulses is 3 cycles (START, WAIT with eoc, IDLE). This guarantees the SAR logic has returned to its wait state before it sees the next cnvst.
- eoc_in outside WAIT is ignored: no push, no flag.
- FIFO:
  - First-word fall-through: m_data = head whenever m_valid=1.
  - Pop when m_valid & m_ready.
  - Push while full without a same-cycle pop: result dropped, overflow set, conv_count unchanged.
  - Push while full with a same-cycle pop: push accepted, no overflow.
  - Push to empty: m_valid rises the next cycle.
  - m_ready while empty has no effect.
- conv_count increments once per accepted push.
- Sticky flags: if clr_flags coincides with a new set event, set wins.
- m_data holds its last value when the FIFO is empty; m_data is undefined to the consumer when m_valid=0.
- Width rule: the timeout counter is sized ceil(log2(TIMEOUT+1)) bits.

Decomposition:
- Shared package sar_pkg:
  - FSM state encoding (IDLE/START/WAIT).
  - SAR_DATA_W=10 constant, shared with the SAR controller.
  - Default TIMEOUT.
- One sub-module, sar_result_fifo: parameterised sync FIFO (DATA_W, FIFO_DEPTH), FWFT, full/empty, push/pop with simultaneous-op rule above.
- Trigger, FSM, counters and flags stay in the top.

Test Plan:
- Single conversion:
  - Stimulus: pulse single; SAR model returns eoc 12 cycles after cnvst with sar_in=0x2A5.
  - Required: cnvst is high for exactly 1 cycle, 2 cycles after single; m_valid=1 with m_data=0x2A5 the cycle after eoc; conv_count=1.
- Periodic mode:
  - Stimulus: enable=1, rate=20, SAR model eoc latency 12.
  - Required: cnvst pulses every 21 cycles; 5 results read in order with m_ready=1.
- Overflow:
  - Stimulus: m_ready=0, rate=0, 5 conversions.
  - Required: the first 4 codes are buffered; the 5th is dropped and overflow=1; conv_count=4.
  - Then: clr_flags -> overflow=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full, eoc coincides with m_ready=1.
  - Required: no overflow; depth stays 4; the new code appears at the tail.
- Timeout:
  - Stimulus: SAR model never asserts eoc.
  - Required: timeout=1 after 31 WAIT cycles; FSM returns to IDLE; no push.
  - Then: eoc_in pulsed in IDLE is ignored.
- Reset mid-conversion:
  - Stimulus: assert rst_n=0 during WAIT with 2 results queued.
  - Required: immediately m_valid=0, busy=0, cnvst=0, conv_count=0.
  - After release: a single request produces a normal conversion.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller and its host-side result reader.
package sar_pkg;

  localparam int unsigned SAR_DATA_W      = 10;
  localparam int unsigned SAR_TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_result_fifo.sv
// First-word-fall-through result buffer; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sar_result_fifo #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              valid_o,
  output logic              accept_c_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q;
  logic              full_c, pop_ok_c, push_ok_c;

  always_comb begin
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    pop_ok_c  = pop_i & (count_q != '0);
    push_ok_c = push_i & (~full_c | pop_ok_c);
    wr_ptr_d  = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    // Next head comes straight from data_i when it lands in the slot becoming the head.
    head_d    = head_q;
    if (count_d != '0) begin
      if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
        head_d = data_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign head_o     = head_q;
  assign valid_o    = valid_q;
  assign accept_c_o = push_ok_c;

endmodule

// File: rtl/sar_result_reader.sv
// Host-side SAR reader: triggers conversions, waits for eoc with a timeout and
// buffers results on a valid/ready stream with sticky overflow/timeout flags.
module sar_result_reader
  import sar_pkg::*;
#(
  parameter int unsigned DATA_W     = SAR_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = SAR_TIMEOUT_DEF,
  parameter int unsigned RATE_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  input  logic              single,
  output logic              cnvst,
  input  logic [DATA_W-1:0] sar_in,
  input  logic              eoc_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              overflow,
  output logic              timeout,
  input  logic              clr_flags,
  output logic [15:0]       conv_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  sar_state_e        state_q, state_d;
  logic              pending_q, pending_d;
  logic [RATE_W-1:0] per_cnt_q, per_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              cnvst_q, busy_q, ovf_q, tmo_q;
  logic [15:0]       count_q;
  logic              trig_c, push_c, tmo_hit_c, pop_c, accept_c;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    per_cnt_d = '0;
    tmo_cnt_d = tmo_cnt_q;
    trig_c    = 1'b0;
    push_c    = 1'b0;
    tmo_hit_c = 1'b0;

    if (enable) begin
      if (per_cnt_q == '0) begin
        per_cnt_d = rate;
        trig_c    = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q - RATE_W'(1);
      end
    end
    if (single || trig_c) begin
      pending_d = 1'b1;
    end

    // Consuming pending in IDLE wins over a coincident trigger (one-deep request).
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_START;
          pending_d = 1'b0;
        end
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (eoc_in) begin
          push_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
            tmo_hit_c = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop_c = m_valid & m_ready;

  sar_result_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_c),
    .data_i    (sar_in),
    .pop_i     (pop_c),
    .head_o    (m_data),
    .valid_o   (m_valid),
    .accept_c_o(accept_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      per_cnt_q <= '0;
      tmo_cnt_q <= '0;
      cnvst_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      per_cnt_q <= per_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      cnvst_q   <= (state_d == ST_START);
      busy_q    <= (state_d != ST_IDLE);
      if (push_c && !accept_c) begin
        ovf_q <= 1'b1;
      end else if (clr_flags) begin
        ovf_q <= 1'b0;
      end
      if (tmo_hit_c) begin
        tmo_q <= 1'b1;
      end else if (clr_flags) begin
        tmo_q <= 1'b0;
      end
      if (accept_c) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign cnvst      = cnvst_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign timeout    = tmo_q;
  assign conv_count = count_q;

endmodule

// File: tb/tb_sar_result_reader.sv
// Scoreboard bench for sar_result_reader with a behavioural SAR responder.
module tb_sar_result_reader;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [RW-1:0] rate = '0;
  logic          single = 1'b0;
  logic          cnvst;
  logic [DW-1:0] sar_in = '0;
  logic          eoc_in = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          overflow;
  logic          timeout;
  logic          clr_flags = 1'b0;
  logic [15:0]   conv_count;

  always #5 clk = ~clk;

  sar_result_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rate      (rate),
    .single    (single),
    .cnvst     (cnvst),
    .sar_in    (sar_in),
    .eoc_in    (eoc_in),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .overflow  (overflow),
    .timeout   (timeout),
    .clr_flags (clr_flags),
    .conv_count(conv_count)
  );

  int            errs = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            cnv_cyc[$];
  int            sar_lat = 12;
  bit            sar_dead = 1'b0;
  int            lat_cnt = 0;
  logic [DW-1:0] next_code = '0;
  bit            eoc_model = 1'b0;
  bit            ready_on_eoc = 1'b0;
  bit            rdy_pulse = 1'b0;
  bit            prev_cnvst = 1'b0;
  int            exp_cnt = 0;
  bit            exp_ovf = 1'b0;
  int            pops = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: score the handshake/push about to happen, then advance the SAR responder.
  task automatic tick();
    if (m_valid && m_ready) begin
      pops++;
      if (exp_q.size() == 0) check("pop_extra", 32'(m_valid), 32'd0);
      else check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    if (eoc_in && eoc_model) begin
      if (exp_q.size() < int'(DEPTH)) begin
        exp_q.push_back(sar_in);
        exp_cnt++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    single    = 1'b0;
    clr_flags = 1'b0;
    eoc_in    = 1'b0;
    eoc_model = 1'b0;
    if (rdy_pulse) begin
      m_ready   = 1'b0;
      rdy_pulse = 1'b0;
    end
    if (cnvst) begin
      check("cnvst_width", 32'(prev_cnvst), 32'd0);
      cnv_cyc.push_back(cyc);
      lat_cnt = sar_dead ? 0 : sar_lat;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        eoc_in    = 1'b1;
        eoc_model = 1'b1;
        sar_in    = next_code;
        next_code = next_code + 10'h0D3;
        if (ready_on_eoc) begin
          m_ready   = 1'b1;
          rdy_pulse = 1'b1;
        end
      end
    end
    prev_cnvst = cnvst;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cnvst"}, 32'(cnvst), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_tmo"}, 32'(timeout), 32'd0);
    check({tag, "_count"}, 32'(conv_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    exp_q.delete();
    cnv_cyc.delete();
    lat_cnt = 0; exp_cnt = 0; exp_ovf = 1'b0; prev_cnvst = 1'b0;
    eoc_in = 1'b0; eoc_model = 1'b0; single = 1'b0; enable = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  task automatic one_conv();
    single = 1'b1;
    tick();
    for (int g = 0; g < 10 && !busy; g++) tick();
    for (int g = 0; g < 80 && busy; g++) tick();
    check("conv_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int s0;
    int c0;
    #2;
    do_reset("rst0");

    // Single conversion
    m_ready = 1'b1; next_code = 10'h2A5; sar_lat = 12; pops = 0;
    single = 1'b1; s0 = cyc;
    tick();
    for (int g = 0; g < 20 && cnv_cyc.size() == 0; g++) tick();
    check("t1_cnvst_seen", 32'(cnv_cyc.size()), 32'd1);
    if (cnv_cyc.size() > 0) check("t1_single_to_cnvst", 32'(cnv_cyc[0] - s0), 32'd2);
    for (int g = 0; g < 20 && !eoc_in; g++) tick();
    check("t1_valid_at_eoc", 32'(m_valid), 32'd0);
    tick();
    check("t1_valid", 32'(m_valid), 32'd1);
    check("t1_data", 32'(m_data), 32'h2A5);
    tick();
    check("t1_count", 32'(conv_count), 32'd1);
    check("t1_pops", 32'(pops), 32'd1);

    // Periodic mode
    cnv_cyc.delete(); pops = 0; next_code = 10'h101; rate = 8'd20; enable = 1'b1;
    for (int g = 0; g < 300 && pops < 5; g++) tick();
    enable = 1'b0;
    check("t2_pops", 32'(pops), 32'd5);
    if (cnv_cyc.size() >= 5) begin
      for (int i = 1; i < 5; i++) check("t2_period", 32'(cnv_cyc[i] - cnv_cyc[i-1]), 32'd21);
    end else begin
      check("t2_cnvst_n", 32'(cnv_cyc.size()), 32'd5);
    end
    for (int g = 0; g < 30; g++) tick();
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_count", 32'(conv_count), 32'd6);

    // Overflow at minimum spacing
    do_reset("rst1");
    rate = 8'd0; sar_lat = 1; next_code = 10'h3F0; enable = 1'b1;
    for (int g = 0; g < 200 && cnv_cyc.size() < 5; g++) tick();
    enable = 1'b0;
    for (int g = 0; g < 20 && busy; g++) tick();
    tick();
    check("t3_cnvst_n", 32'(cnv_cyc.size()), 32'd5);
    if (cnv_cyc.size() >= 2) check("t3_min_space", 32'(cnv_cyc[1] - cnv_cyc[0]), 32'd3);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_ovf_model", 32'(exp_ovf), 32'd1);
    check("t3_count", 32'(conv_count), 32'd4);
    check("t3_head", 32'(m_data), 32'h3F0);
    clr_flags = 1'b1;
    tick();
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    pops = 0; m_ready = 1'b1;
    for (int g = 0; g < 20 && (m_valid || pops == 0); g++) tick();
    m_ready = 1'b0;
    check("t3_drain", 32'(pops), 32'd4);

    // Full FIFO with push and pop in the same cycle
    sar_lat = 4; next_code = 10'h011;
    for (int k = 0; k < 4; k++) one_conv();
    check("t4_full_count", 32'(conv_count), 32'(exp_cnt));
    ready_on_eoc = 1'b1;
    one_conv();
    ready_on_eoc = 1'b0;
    check("t4_no_ovf", 32'(overflow), 32'd0);
    check("t4_count", 32'(conv_count), 32'd9);
    pops = 0; m_ready = 1'b1;
    for (int g = 0; g < 20 && (m_valid || pops == 0); g++) tick();
    m_ready = 1'b0;
    check("t4_depth", 32'(pops), 32'd4);

    // Timeout: SAR never answers
    sar_dead = 1'b1; cnv_cyc.delete();
    single = 1'b1;
    tick();
    for (int g = 0; g < 20 && cnv_cyc.size() == 0; g++) tick();
    check("t5_cnvst_seen", 32'(cnv_cyc.size()), 32'd1);
    c0 = (cnv_cyc.size() > 0) ? cnv_cyc[0] : cyc;
    for (int g = 0; g < 60 && cyc < c0 + 31; g++) tick();
    check("t5_tmo_early", 32'(timeout), 32'd0);
    check("t5_busy_early", 32'(busy), 32'd1);
    tick();
    check("t5_tmo", 32'(timeout), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_no_push", 32'(m_valid), 32'd0);
    sar_dead = 1'b0;
    eoc_in = 1'b1; sar_in = 10'h155;
    tick();
    tick();
    check("t5_eoc_idle_valid", 32'(m_valid), 32'd0);
    check("t5_eoc_idle_count", 32'(conv_count), 32'd9);
    check("t5_eoc_idle_ovf", 32'(overflow), 32'd0);
    clr_flags = 1'b1;
    tick();
    check("t5_tmo_clr", 32'(timeout), 32'd0);

    // Reset during WAIT with two results queued
    sar_lat = 12; next_code = 10'h0F0;
    one_conv();
    one_conv();
    check("t6_queued", 32'(m_valid), 32'd1);
    single = 1'b1;
    tick();
    for (int g = 0; g < 10 && !busy; g++) tick();
    for (int g = 0; g < 4; g++) tick();
    check("t6_in_wait", 32'(busy), 32'd1);
    do_reset("t6_rst");
    m_ready = 1'b1; pops = 0; next_code = 10'h1C3;
    one_conv();
    tick();
    tick();
    check("t6_pops", 32'(pops), 32'd1);
    check("t6_count", 32'(conv_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
